// File: rtl/amp_seq.sv
// Class-D amplifier power/fault sequencer: holds the amps in shutdown until the EQ
// queues fill, unmutes after a pop-suppression window, filters faults, retries, locks out.
module amp_seq #(
  parameter int unsigned FLT_FILT       = 4,
  parameter int unsigned UNMUTE_SAMPLES = 8,
  parameter int unsigned RETRY_WAIT     = 1024,
  parameter int unsigned MAX_FAULTS     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seq_low,
  input  logic       vld,
  input  logic       Flt_n,
  output logic       sht_dwn,
  output logic       mute,
  output logic [3:0] fault_cnt,
  output logic       lockout,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    WAIT_Q = 3'd0,
    POP    = 3'd1,
    RUN    = 3'd2,
    FAULT  = 3'd3,
    LOCK   = 3'd4
  } state_t;

  localparam int unsigned FW = $clog2(FLT_FILT + 1);
  localparam int unsigned PW = $clog2(UNMUTE_SAMPLES + 1);
  localparam int unsigned RW = $clog2(RETRY_WAIT + 1);

  localparam logic [FW-1:0] FILT_MAX  = FW'(FLT_FILT);
  localparam logic [PW-1:0] POP_LAST  = PW'(UNMUTE_SAMPLES - 1);
  localparam logic [RW-1:0] RETRY_END = RW'(RETRY_WAIT - 1);
  localparam logic [3:0]    FLT_LIMIT = 4'(MAX_FAULTS);

  state_t        state_q, state_d;
  logic          flt_q1, flt_s;
  logic [FW-1:0] filt_cnt;
  logic [PW-1:0] pop_cnt;
  logic [RW-1:0] retry_cnt;
  logic [3:0]    fault_cnt_q, fault_cnt_d, fault_inc;
  logic          fault, entering;

  assign fault     = (filt_cnt == FILT_MAX);
  assign fault_inc = (fault_cnt_q == 4'hF) ? 4'hF : fault_cnt_q + 4'd1;
  assign entering  = (state_d != state_q);

  always_comb begin
    state_d     = state_q;
    fault_cnt_d = fault_cnt_q;
    case (state_q)
      WAIT_Q: if (seq_low) state_d = POP;
      POP, RUN: begin
        // Fault outranks a coincident final vld; the lockout decision uses the
        // post-increment count so the Nth fault lands directly in LOCK.
        if (fault) begin
          fault_cnt_d = fault_inc;
          state_d     = (fault_inc >= FLT_LIMIT) ? LOCK : FAULT;
        end else if (state_q == POP && vld && pop_cnt == POP_LAST) begin
          state_d = RUN;
        end
      end
      // Leave on the edge the fault-free timer reaches RETRY_WAIT.
      FAULT:   if (flt_s && retry_cnt == RETRY_END) state_d = WAIT_Q;
      LOCK:    state_d = LOCK;
      default: state_d = WAIT_Q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_Q;
      sht_dwn     <= 1'b1;
      mute        <= 1'b1;
      fault_cnt_q <= 4'd0;
      flt_q1      <= 1'b1;
      flt_s       <= 1'b1;
      filt_cnt    <= '0;
      pop_cnt     <= '0;
      retry_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      sht_dwn     <= !(state_d == POP || state_d == RUN);
      mute        <= (state_d != RUN);
      fault_cnt_q <= fault_cnt_d;
      flt_q1      <= Flt_n;
      flt_s       <= flt_q1;

      if (entering || flt_s)   filt_cnt <= '0;
      else if (!fault)         filt_cnt <= filt_cnt + 1'b1;

      if (entering)                   pop_cnt <= '0;
      else if (state_q == POP && vld) pop_cnt <= pop_cnt + 1'b1;

      if (entering || state_q != FAULT || !flt_s) retry_cnt <= '0;
      else                                        retry_cnt <= retry_cnt + 1'b1;
    end
  end

  assign fault_cnt = fault_cnt_q;
  assign lockout   = (state_q == LOCK);
  assign state     = state_q;

endmodule

// File: tb/tb_amp_seq.sv
// Directed bench for amp_seq: power-up, fault filtering/latency, retry timing,
// POP-phase fault priority, lockout and mid-run reset.
module tb_amp_seq;

  localparam int FLT_FILT = 4;
  localparam int UNMUTE   = 8;
  localparam int RETRY    = 100;
  localparam int MAXF     = 3;

  logic       clk = 1'b0;
  logic       rst, seq_low, vld, Flt_n;
  logic       sht_dwn, mute, lockout;
  logic [3:0] fault_cnt;
  logic [2:0] state;

  int tests_run    = 0;
  int tests_failed = 0;

  amp_seq #(
    .FLT_FILT(FLT_FILT), .UNMUTE_SAMPLES(UNMUTE),
    .RETRY_WAIT(RETRY), .MAX_FAULTS(MAXF)
  ) dut (
    .clk(clk), .rst(rst), .seq_low(seq_low), .vld(vld), .Flt_n(Flt_n),
    .sht_dwn(sht_dwn), .mute(mute), .fault_cnt(fault_cnt),
    .lockout(lockout), .state(state)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // status word: {state, sht_dwn, mute, fault_cnt, lockout}
  function automatic logic [9:0] obs();
    return {state, sht_dwn, mute, fault_cnt, lockout};
  endfunction

  function automatic logic [9:0] st(input logic [2:0] s, input logic sd, input logic mu,
                                    input logic [3:0] fc, input logic lo);
    return {s, sd, mu, fc, lo};
  endfunction

  task automatic power_to_run();
    seq_low = 1'b1;
    step(1);
    seq_low = 1'b0;
    repeat (UNMUTE) begin
      vld = 1'b1; step(1);
      vld = 1'b0; step(1);
    end
  endtask

  task automatic test_reset();
    logic [9:0] e;
    rst = 1'b1; seq_low = 1'b0; vld = 1'b0; Flt_n = 1'b1;
    step(2);
    rst = 1'b0;
    e = st(3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL reset_state: got %b want %b", obs(), e);
    end
    step(500);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL wait_q_hold: got %b want %b", obs(), e);
    end
  endtask

  task automatic test_power_up();
    logic [9:0] e;
    seq_low = 1'b1;
    step(1);
    seq_low = 1'b0;
    e = st(3'd1, 1'b0, 1'b1, 4'd0, 1'b0);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL pop_entry: got %b want %b", obs(), e);
    end
    repeat (UNMUTE - 1) begin
      vld = 1'b1; step(1);
      vld = 1'b0; step(1);
    end
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL pop_7_samples: got %b want %b", obs(), e);
    end
    vld = 1'b1; step(1); vld = 1'b0;
    e = st(3'd2, 1'b0, 1'b0, 4'd0, 1'b0);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL run_unmute: got %b want %b", obs(), e);
    end
  endtask

  task automatic test_glitch();
    logic [9:0] e;
    Flt_n = 1'b0; step(FLT_FILT - 1);
    Flt_n = 1'b1; step(10);
    e = st(3'd2, 1'b0, 1'b0, 4'd0, 1'b0);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL glitch_ignored: got %b want %b", obs(), e);
    end
  endtask

  task automatic test_fault_latency();
    logic [9:0] e;
    Flt_n = 1'b0;
    step(FLT_FILT + 2);
    e = st(3'd2, 1'b0, 1'b0, 4'd0, 1'b0);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL fault_early: got %b want %b", obs(), e);
    end
    step(1);
    e = st(3'd3, 1'b1, 1'b1, 4'd1, 1'b0);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL fault_entry: got %b want %b", obs(), e);
    end
    step(43);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL fault_hold: got %b want %b", obs(), e);
    end
  endtask

  // Release, then a 1-cycle low pulse when the timer is at 90 restarts the count.
  task automatic test_retry();
    logic [9:0] e;
    Flt_n = 1'b1; step(92);
    Flt_n = 1'b0; step(1);
    Flt_n = 1'b1; step(9);
    e = st(3'd3, 1'b1, 1'b1, 4'd1, 1'b0);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL retry_restarted: got %b want %b", obs(), e);
    end
    step(92);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL retry_one_short: got %b want %b", obs(), e);
    end
    step(1);
    e = st(3'd0, 1'b1, 1'b1, 4'd1, 1'b0);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL retry_exit: got %b want %b", obs(), e);
    end
  endtask

  // 5 samples, fault starts, samples 6 and 7 during filtering, sample 8 on the fault edge.
  task automatic test_pop_fault();
    logic [9:0] e;
    seq_low = 1'b1; step(1); seq_low = 1'b0;
    repeat (5) begin
      vld = 1'b1; step(1);
      vld = 1'b0; step(1);
    end
    Flt_n = 1'b0;
    e = st(3'd1, 1'b0, 1'b1, 4'd1, 1'b0);
    for (int k = 1; k <= FLT_FILT + 3; k++) begin
      vld = (k == 2 || k == 4 || k == FLT_FILT + 3);
      step(1);
      if (k < FLT_FILT + 3) begin
        tests_run++;
        if (obs() !== e) begin
          tests_failed++;
          $display("FAIL pop_fault_k%0d: got %b want %b", k, obs(), e);
        end
      end
    end
    vld = 1'b0;
    e = st(3'd3, 1'b1, 1'b1, 4'd2, 1'b0);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL pop_fault_wins: got %b want %b", obs(), e);
    end
    Flt_n = 1'b1; step(RETRY + 1);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL retry2_early: got %b want %b", obs(), e);
    end
    step(1);
    e = st(3'd0, 1'b1, 1'b1, 4'd2, 1'b0);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL retry2_exit: got %b want %b", obs(), e);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [9:0] e;
    power_to_run();
    e = st(3'd2, 1'b0, 1'b0, 4'd2, 1'b0);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL run_cnt2: got %b want %b", obs(), e);
    end
    rst = 1'b1; step(1); rst = 1'b0;
    e = st(3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL mid_run_reset: got %b want %b", obs(), e);
    end
  endtask

  task automatic test_lockout();
    logic [9:0] e;
    for (int i = 1; i <= MAXF; i++) begin
      power_to_run();
      Flt_n = 1'b0;
      step(FLT_FILT + 3);
      if (i < MAXF) begin
        e = st(3'd3, 1'b1, 1'b1, 4'(i), 1'b0);
        tests_run++;
        if (obs() !== e) begin
          tests_failed++;
          $display("FAIL lock_fault%0d: got %b want %b", i, obs(), e);
        end
        Flt_n = 1'b1; step(RETRY + 2);
        e = st(3'd0, 1'b1, 1'b1, 4'(i), 1'b0);
        tests_run++;
        if (obs() !== e) begin
          tests_failed++;
          $display("FAIL lock_retry%0d: got %b want %b", i, obs(), e);
        end
      end
    end
    e = st(3'd4, 1'b1, 1'b1, 4'd3, 1'b1);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL lock_entry: got %b want %b", obs(), e);
    end
    Flt_n = 1'b1; step(RETRY + 10);
    for (int k = 0; k < 60; k++) begin
      seq_low = (k % 2 == 0);
      Flt_n   = (k % 3 != 0);
      vld     = (k % 4 == 0);
      step(1);
    end
    seq_low = 1'b0; Flt_n = 1'b1; vld = 1'b0;
    step(5);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL lock_terminal: got %b want %b", obs(), e);
    end
    rst = 1'b1; step(1); rst = 1'b0;
    e = st(3'd0, 1'b1, 1'b1, 4'd0, 1'b0);
    tests_run++;
    if (obs() !== e) begin
      tests_failed++;
      $display("FAIL lock_reset: got %b want %b", obs(), e);
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_glitch();
    test_fault_latency();
    test_retry();
    test_pop_fault();
    test_reset_mid_run();
    test_lockout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
